// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: instruction memory read port plus the instruction
// valid/ready hand-off towards the control unit.
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [14:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid,
        input  imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid,
        output imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues single-cycle-latency memory
// reads and buffers returned instructions in a 2-entry FIFO with redirect flush.
module pc_fetch_stage #(
    parameter logic [14:0] RESET_PC = 15'd0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [14:0]      pc,
    input  logic [14:0]      next_pc,
    input  logic             redirect,
    input  logic [14:0]      redirect_pc,
    pc_fetch_stage_if.master bus
);

    typedef enum logic [1:0] {StBoot, StRun, StRedir} state_e;

    state_e      state_q, state_d;
    logic [14:0] pc_q, pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        inflight_q, inflight_d;
    logic [14:0] req_addr_q, req_addr_d;
    logic [31:0] fifo_data_q [2];
    logic [14:0] fifo_pc_q [2];

    logic        redirect_eff;
    logic        pop;
    logic        push;
    logic        req;
    logic [2:0]  occupancy;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        req_addr_d   = pc_q;
        redirect_eff = redirect && (state_q != StBoot);
        pop          = (count_q != 2'd0) && bus.instr_ready;
        // The response of the previous cycle is dropped when a redirect arrives with it.
        push         = inflight_q && !redirect_eff;
        occupancy    = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        req          = (state_q == StRun) && !redirect && (occupancy < 3'd2);
        inflight_d   = req;

        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   state_d = redirect ? StRedir : StRun;
            StRedir: state_d = redirect ? StRedir : StRun;
            default: state_d = StBoot;
        endcase

        if (redirect_eff) begin
            pc_d     = redirect_pc;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (req) begin
                pc_d = next_pc;
            end
            count_d  = count_q + {1'b0, push} - {1'b0, pop};
            rd_ptr_d = rd_ptr_q ^ pop;
            wr_ptr_d = wr_ptr_q ^ push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            inflight_q <= 1'b0;
            req_addr_q <= 15'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            inflight_q <= inflight_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= 32'd0;
                fifo_pc_q[i]   <= 15'd0;
            end
        end else if (push) begin
            fifo_data_q[wr_ptr_q] <= bus.imem_rdata;
            fifo_pc_q[wr_ptr_q]   <= req_addr_q;
        end
    end

    always_comb begin
        pc              = pc_q;
        bus.imem_req    = req;
        bus.imem_addr   = pc_q;
        bus.instr       = fifo_data_q[rd_ptr_q];
        bus.instr_pc    = fifo_pc_q[rd_ptr_q];
        bus.instr_valid = (count_q != 2'd0);
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a queue of expected fetch PCs is compared
// against every instruction handed over, alongside cycle-level checks.
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] pc;
    logic [14:0] next_pc;
    logic        redirect;
    logic [14:0] redirect_pc;

    pc_fetch_stage_if bus ();

    pc_fetch_stage #(.RESET_PC(15'd0)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    assign next_pc = pc + 15'd1;

    // Memory returns a tagged word one cycle after each request.
    always @(posedge clk)
        bus.imem_rdata <= bus.imem_req ? (32'h1000_0000 + {17'd0, bus.imem_addr}) : 32'h0;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_req    = 0;
    logic [14:0] sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (bus.imem_req === 1'b1) n_req++;
            if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
                logic [14:0] e;
                check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("deliver_pc", {17'd0, bus.instr_pc}, {17'd0, e});
                    check("deliver_instr", bus.instr, 32'h1000_0000 + {17'd0, e});
                end
            end
        end
    end

    task automatic cycle_start();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_range(input logic [14:0] base, input int n);
        for (int i = 0; i < n; i++) sb.push_back(base + 15'(i));
    endtask

    // Leaves the bench at the start of cycle 1 (the BOOT cycle) after release.
    task automatic do_reset(input logic ready);
        reset           = 1'b0;
        redirect        = 1'b0;
        redirect_pc     = 15'd0;
        bus.instr_ready = ready;
        cycle_start();
        mid();
        check("rst_pc", {17'd0, pc}, 32'd0);
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", {17'd0, bus.instr_pc}, 32'd0);
        cycle_start();
        sb.delete();
        n_req = 0;
        reset = 1'b1;
    endtask

    initial begin
        // Basic stream, one instruction per cycle.
        do_reset(1'b1);
        push_range(15'd0, 16);
        mid();
        check("boot_req", {31'd0, bus.imem_req}, 32'd0);
        cycle_start(); mid();
        check("c2_req", {31'd0, bus.imem_req}, 32'd1);
        check("c2_addr", {17'd0, bus.imem_addr}, 32'd0);
        cycle_start(); mid();
        check("c3_addr", {17'd0, bus.imem_addr}, 32'd1);
        check("c3_valid", {31'd0, bus.instr_valid}, 32'd0);
        cycle_start(); mid();
        check("c4_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("c4_instr_pc", {17'd0, bus.instr_pc}, 32'd0);
        check("c4_addr", {17'd0, bus.imem_addr}, 32'd2);
        for (int i = 3; i < 9; i++) begin
            cycle_start(); mid();
            check("stream_req", {31'd0, bus.imem_req}, 32'd1);
            check("stream_addr", {17'd0, bus.imem_addr}, i);
        end

        // Back-pressure: buffer fills with two entries and fetch stalls.
        do_reset(1'b0);
        push_range(15'd0, 8);
        for (int i = 0; i < 5; i++) cycle_start();
        mid();
        check("full_pc", {17'd0, pc}, 32'd2);
        check("full_req", {31'd0, bus.imem_req}, 32'd0);
        check("full_nreq", n_req, 32'd2);
        check("full_instr_pc", {17'd0, bus.instr_pc}, 32'd0);
        check("full_instr", bus.instr, 32'h1000_0000);
        cycle_start();
        bus.instr_ready = 1'b1;
        mid();
        check("resume_req", {31'd0, bus.imem_req}, 32'd1);
        check("resume_addr", {17'd0, bus.imem_addr}, 32'd2);
        for (int i = 0; i < 5; i++) cycle_start();

        // Redirect with one buffered entry and one request in flight.
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) cycle_start();
        redirect    = 1'b1;
        redirect_pc = 15'h0100;
        mid();
        check("redir_req", {31'd0, bus.imem_req}, 32'd0);
        check("redir_pre_valid", {31'd0, bus.instr_valid}, 32'd1);
        cycle_start();
        redirect        = 1'b0;
        bus.instr_ready = 1'b1;
        sb.delete();
        push_range(15'h0100, 16);
        mid();
        check("bubble_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("bubble_req", {31'd0, bus.imem_req}, 32'd0);
        check("bubble_pc", {17'd0, pc}, 32'h0100);
        cycle_start(); mid();
        check("redir_fetch_req", {31'd0, bus.imem_req}, 32'd1);
        check("redir_fetch_addr", {17'd0, bus.imem_addr}, 32'h0100);
        cycle_start(); mid();
        check("no_stale_valid", {31'd0, bus.instr_valid}, 32'd0);
        cycle_start(); mid();
        check("redir_first_pc", {17'd0, bus.instr_pc}, 32'h0100);
        cycle_start(); cycle_start();

        // Back-to-back redirects: only the second target survives.
        cycle_start();
        redirect    = 1'b1;
        redirect_pc = 15'h0040;
        mid();
        check("dbl_req0", {31'd0, bus.imem_req}, 32'd0);
        cycle_start();
        sb.delete();
        push_range(15'h0080, 16);
        redirect_pc = 15'h0080;
        mid();
        check("dbl_valid1", {31'd0, bus.instr_valid}, 32'd0);
        check("dbl_pc1", {17'd0, pc}, 32'h0040);
        cycle_start();
        redirect = 1'b0;
        mid();
        check("dbl_pc2", {17'd0, pc}, 32'h0080);
        check("dbl_req2", {31'd0, bus.imem_req}, 32'd0);
        cycle_start(); mid();
        check("dbl_addr3", {17'd0, bus.imem_addr}, 32'h0080);
        check("dbl_req3", {31'd0, bus.imem_req}, 32'd1);
        cycle_start(); cycle_start(); mid();
        check("dbl_first_pc", {17'd0, bus.instr_pc}, 32'h0080);
        cycle_start(); cycle_start();

        // PC wrap at the top of the 15-bit space.
        cycle_start();
        redirect    = 1'b1;
        redirect_pc = 15'h7FFE;
        cycle_start();
        redirect = 1'b0;
        sb.delete();
        push_range(15'h7FFE, 8);
        cycle_start(); mid();
        check("wrap_addr0", {17'd0, bus.imem_addr}, 32'h7FFE);
        cycle_start(); mid();
        check("wrap_addr1", {17'd0, bus.imem_addr}, 32'h7FFF);
        cycle_start(); mid();
        check("wrap_addr2", {17'd0, bus.imem_addr}, 32'h0000);
        cycle_start(); cycle_start(); mid();
        check("wrap_instr_pc", {17'd0, bus.instr_pc}, 32'h0000);
        cycle_start();

        // Asynchronous reset mid-stream with a full buffer.
        cycle_start();
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle_start();
        mid();
        check("pre_rst_valid", {31'd0, bus.instr_valid}, 32'd1);
        check("pre_rst_req", {31'd0, bus.imem_req}, 32'd0);
        cycle_start();
        #2;
        reset = 1'b0;
        #1;
        check("async_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("async_pc", {17'd0, pc}, 32'd0);
        check("async_req", {31'd0, bus.imem_req}, 32'd0);
        cycle_start();
        sb.delete();
        n_req = 0;
        bus.instr_ready = 1'b1;
        push_range(15'd0, 8);
        reset = 1'b1;
        mid();
        check("reboot_req", {31'd0, bus.imem_req}, 32'd0);
        cycle_start(); mid();
        check("reboot_req2", {31'd0, bus.imem_req}, 32'd1);
        check("reboot_addr2", {17'd0, bus.imem_addr}, 32'd0);
        cycle_start(); cycle_start(); mid();
        check("reboot_instr_pc", {17'd0, bus.instr_pc}, 32'd0);
        cycle_start(); cycle_start();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001: Parameter RESET_PC, default 15'd0, PC value loaded on reset.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: reset  input  1  asynchronous, active-low reset; state cleared immediately when low, released synchronously to clk.
REQ-004: pc  output  15  current fetch PC register; feeds the PC incrementer.
REQ-005: next_pc  input  15  sequential next PC returned by the PC incrementer (combinational function of pc).
REQ-006: redirect  input  1  taken jump/branch strobe from the control unit (PC_control).
REQ-007: redirect_pc  input  15  jump target (j_instr_addr), sampled when redirect=1.
REQ-008: imem_req  output  1  instruction memory read request.
REQ-009: imem_addr  output  15  read address; equals pc.
REQ-010: imem_rdata  input  32  read data, valid exactly one cycle after an imem_req cycle.
REQ-011: instr  output  32  instruction at buffer head.
REQ-012: instr_pc  output  15  PC of the instruction at buffer head.
REQ-013: instr_valid  output  1  buffer head holds a valid instruction.
REQ-014: instr_ready  input  1  control unit accepts head; transfer when instr_valid and instr_ready.

Function
REQ-015: FSM states BOOT, RUN, REDIR; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016: imem_req SHALL be 1 only in RUN, with redirect=0 and (count + inflight - pop) < 2, where count = buffer occupancy (0..2), inflight = request issued in previous cycle and not killed, pop = instr_valid and instr_ready.
REQ-017: In a cycle with imem_req=1, pc SHALL load next_pc at the clock edge; otherwise pc holds.
REQ-018: A non-killed response SHALL be written into the 2-entry FIFO as {imem_rdata, address of request} at the end of the response cycle; instr_valid rises the following cycle (request-to-valid latency 2 cycles).
REQ-019: Throughput: with instr_ready held 1 and no redirect, one instruction per cycle in steady state.
REQ-020: Buffer full (count=2, no pop): imem_req=0, pc holds, instr/instr_pc stable until popped.
REQ-021: Simultaneous push and pop SHALL leave count unchanged and preserve order; push into a full buffer SHALL never occur.
REQ-022: redirect=1 (any state except BOOT): pc loads redirect_pc, FIFO flushed (count=0), in-flight response killed, imem_req=0, FSM enters REDIR.
REQ-023: A pop handshake in the redirect cycle SHALL count as consumed; no other buffered entry survives.
REQ-024: REDIR lasts one cycle with imem_req=0, then RUN; redirect in REDIR reloads pc with the new redirect_pc and stays in REDIR one more cycle.
REQ-025: redirect during BOOT SHALL be ignored.
REQ-026: PC arithmetic is 15-bit; wrap from 15'h7FFF to 15'h0000 comes from next_pc and SHALL pass through unmodified.

Reset
REQ-027: While reset=0: pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, count=0, inflight=0, FSM=BOOT.
REQ-028: reset asserted mid-operation SHALL discard the FIFO and in-flight response immediately, without waiting for a clock edge.

Verification
REQ-029: Release reset, instr_ready=1, memory returns 32'h1000_0000+addr, next_pc=pc+1 -> first imem_req in cycle 2 at addr 0; instr_valid in cycle 4 with instr_pc=0; then addr 1,2,3 on consecutive cycles.
REQ-030: instr_ready=0 from start -> exactly two requests (addr 0,1), count=2, pc=2 held; raise instr_ready -> addr 0 then 1 delivered in order, fetch resumes at 2.
REQ-031: Redirect with redirect_pc=15'h0100 while count=1 and one request in flight -> instr_valid=0 next cycle, one bubble cycle, then imem_addr=15'h0100; no stale instruction delivered.
REQ-032: Redirect on consecutive cycles to 15'h0040 then 15'h0080 -> only instructions from 15'h0080 onward appear.
REQ-033: pc=15'h7FFF with next_pc wrapping -> following fetch at 15'h0000, instr_pc=15'h0000.
REQ-034: reset pulsed low mid-stream with count=2 -> instr_valid=0 and pc=RESET_PC asynchronously; BOOT sequence repeats after release.
